// File: rtl/div_pkg.sv
// Shared constants for the EX-stage iterative divider: step count, op bit positions, FSM encoding.
// Also provides the conditional two's-complement helper used for sign handling.
package div_pkg;

    localparam int DIV_ITER          = 32;
    localparam int DIV_OP_SIGNED_BIT = 1;
    localparam int DIV_OP_REM_BIT    = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } div_state_e;

    // Negate when asked; abs(0x8000_0000) stays 0x8000_0000 and is then read as unsigned.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder and trial-subtract.
// Purely combinational, no state.
module div_step (
    input  logic [31:0] rem,
    input  logic        dividend_msb,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic        q_bit
);

    logic [32:0] shifted;
    logic [33:0] diff;

    // rem < divisor always holds, so the shifted value fits in 33 bits and a kept difference fits in 32.
    assign shifted  = {rem, dividend_msb};
    assign diff     = {1'b0, shifted} - {2'b00, divisor};
    assign q_bit    = ~diff[33];
    assign rem_next = q_bit ? diff[31:0] : shifted[31:0];

endmodule

// File: rtl/exe_div_unit.sv
// Iterative 32-bit divider for div.w/mod.w/div.wu/mod.wu: 32 restoring steps, divide-by-zero finishes at once.
// Result is held with div_done until div_ack; div_flush returns to IDLE from any state.
module exe_div_unit
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_req,
    input  logic [1:0]  div_op,
    input  logic [31:0] div_src1,
    input  logic [31:0] div_src2,
    input  logic        div_flush,
    input  logic        div_ack,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] div_result
);

    div_state_e  state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] dvd, dvs, rem, quo, result;
    logic        sign_q, sign_r, op_rem, done;
    logic        s1, s2, accept, last_step, q_bit;
    logic [31:0] rem_nxt, q_final;

    assign s1        = div_op[DIV_OP_SIGNED_BIT] & div_src1[31];
    assign s2        = div_op[DIV_OP_SIGNED_BIT] & div_src2[31];
    assign accept    = (state == IDLE) & div_req & ~div_flush;
    assign last_step = (state == CALC) & (cnt == 5'(DIV_ITER - 1));

    div_step u_step (
        .rem          (rem),
        .dividend_msb (dvd[31]),
        .divisor      (dvs),
        .rem_next     (rem_nxt),
        .q_bit        (q_bit)
    );

    assign q_final = {quo[30:0], q_bit};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (div_src2 == 32'd0) ? DONE : CALC;
            CALC:    if (last_step) state_nxt = DONE;
            DONE:    if (div_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (div_flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt    <= 5'd0;
            dvd    <= 32'd0;
            dvs    <= 32'd0;
            rem    <= 32'd0;
            quo    <= 32'd0;
            result <= 32'd0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            op_rem <= 1'b0;
            done   <= 1'b0;
        end else if (div_flush) begin
            done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (div_req) begin
                        op_rem <= div_op[DIV_OP_REM_BIT];
                        sign_q <= s1 ^ s2;
                        sign_r <= s1;
                        dvd    <= neg_if(div_src1, s1);
                        dvs    <= neg_if(div_src2, s2);
                        rem    <= 32'd0;
                        quo    <= 32'd0;
                        cnt    <= 5'd0;
                        // Divide-by-zero bypasses the iteration and the sign fix-up entirely.
                        if (div_src2 == 32'd0) begin
                            result <= div_op[DIV_OP_REM_BIT] ? div_src1 : 32'hFFFF_FFFF;
                            done   <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    quo <= q_final;
                    dvd <= {dvd[30:0], 1'b0};
                    cnt <= cnt + 5'd1;
                    if (last_step) begin
                        result <= op_rem ? neg_if(rem_nxt, sign_r) : neg_if(q_final, sign_q);
                        done   <= 1'b1;
                    end
                end
                DONE: begin
                    if (div_ack) done <= 1'b0;
                end
                default: done <= 1'b0;
            endcase
        end
    end

    assign div_busy   = (state != IDLE);
    assign div_done   = done;
    assign div_result = result;

endmodule
